// File: rtl/mul_seq.sv
// mul_seq: sequential 8x8 unsigned shift-add multiplier.
// One shared 8-bit ripple adder is used once per cycle for eight cycles.
// The product is held in a register and reaches the tri-state bus when oe is high.
// Optional build macro: MUL_SEQ_ZERO_SKIP_EN. When it is defined, a zero operand
// skips RUN and goes straight to DONE with a zero product.

module mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        oe,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  mcand_q, mcand_d;
  logic [7:0]  mplier_q, mplier_d;
  logic [7:0]  accHi_q, accHi_d;
  logic [7:0]  accLo_q, accLo_d;
  logic [2:0]  count_q, count_d;
  logic [15:0] product_q, product_d;

  logic [7:0]  addend;
  logic [8:0]  sum;
  logic        carry;

  // Shared ripple-carry adder: accHi plus the multiplicand when the current multiplier bit is set.
  always_comb begin
    addend = mplier_q[0] ? mcand_q : 8'h00;
    carry  = 1'b0;
    sum    = 9'h000;
    for (int i = 0; i < 8; i++) begin
      sum[i] = accHi_q[i] ^ addend[i] ^ carry;
      carry  = (accHi_q[i] & addend[i]) | (carry & (accHi_q[i] ^ addend[i]));
    end
    sum[8] = carry;
  end

  // Next-state and datapath updates for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    accHi_d   = accHi_q;
    accLo_d   = accLo_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          accHi_d  = 8'h00;
          accLo_d  = 8'h00;
          count_d  = 3'd0;
`ifdef MUL_SEQ_ZERO_SKIP_EN
          if ((a == 8'h00) || (b == 8'h00)) begin
            state_d   = DONE;
            product_d = 16'h0000;
          end else begin
            state_d = RUN;
          end
`else
          state_d = RUN;
`endif
        end
      end
      RUN: begin
        accHi_d  = sum[8:1];
        accLo_d  = {sum[0], accLo_q[7:1]};
        mplier_d = {1'b0, mplier_q[7:1]};
        count_d  = count_q + 3'd1;
        if (count_q == 3'd7) begin
          state_d   = DONE;
          product_d = {sum[8:1], sum[0], accLo_q[7:1]};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything, including the stored product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= 8'h00;
      mplier_q  <= 8'h00;
      accHi_q   <= 8'h00;
      accLo_q   <= 8'h00;
      count_q   <= 3'd0;
      product_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      accHi_q   <= accHi_d;
      accLo_q   <= accLo_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  // Status flags decode directly from the state register.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  assign product = oe ? product_q : 16'hzzzz;

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed self-checking bench for mul_seq.

module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        oe = 1'b1;
  logic [7:0]  a = 8'h00;
  logic [7:0]  b = 8'h00;
  logic        busy;
  logic        done;
  wire  [15:0] product;

  int compared = 0;
  int mismatched = 0;
  int busyCnt;
  int doneCnt;
  int doneEdge;

`ifdef MUL_SEQ_ZERO_SKIP_EN
  localparam int ZERO_DONE_EDGE = 0;
  localparam int ZERO_BUSY_CNT  = 0;
`else
  localparam int ZERO_DONE_EDGE = 8;
  localparam int ZERO_BUSY_CNT  = 8;
`endif

  mul_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .oe      (oe),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Start one multiply from a negedge, then watch busy/done for twelve edges after the capture edge.
  task automatic applyStimulus(input logic [7:0] inA, input logic [7:0] inB, input bit holdStart);
    a     = inA;
    b     = inB;
    start = 1'b1;
    @(posedge clk);
    #1;
    busyCnt  = 0;
    doneCnt  = 0;
    doneEdge = -1;
    if (holdStart) begin
      a = 8'd2;
      b = 8'd3;
    end else begin
      start = 1'b0;
    end
    for (int k = 0; k < 12; k++) begin
      if (busy === 1'b1) busyCnt++;
      if (done === 1'b1) begin
        doneCnt++;
        if (doneEdge < 0) doneEdge = k;
      end
      if (k == 5) start = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    #3;
    checkOutput("reset_busy", {15'd0, busy}, 16'd0);
    checkOutput("reset_done", {15'd0, done}, 16'd0);
    checkOutput("reset_product", product, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 13 * 11
    applyStimulus(8'd13, 8'd11, 1'b0);
    checkOutput("13x11_busy_cycles", 16'(busyCnt), 16'd8);
    checkOutput("13x11_done_count", 16'(doneCnt), 16'd1);
    checkOutput("13x11_done_edge", 16'(doneEdge), 16'd8);
    checkOutput("13x11_product", product, 16'h008F);

    // Output enable is combinational and does not disturb the stored product
    oe = 1'b0;
    #1;
    compared++;
    assert (product === 16'hzzzz) else begin
      mismatched++;
      $error("[TB] FAIL oe0_highz: observed %h expected zzzz", product);
    end
    oe = 1'b1;
    #1;
    checkOutput("oe1_product", product, 16'h008F);

    // 255 * 255 exercises every carry in the adder
    @(negedge clk);
    applyStimulus(8'd255, 8'd255, 1'b0);
    checkOutput("255x255_product", product, 16'hFE01);
    checkOutput("255x255_done_count", 16'(doneCnt), 16'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("255x255_hold", product, 16'hFE01);

    // Zero operand
    @(negedge clk);
    applyStimulus(8'd0, 8'd200, 1'b0);
    checkOutput("0x200_product", product, 16'h0000);
    checkOutput("0x200_done_edge", 16'(doneEdge), 16'(ZERO_DONE_EDGE));
    checkOutput("0x200_busy_cycles", 16'(busyCnt), 16'(ZERO_BUSY_CNT));
    checkOutput("0x200_done_count", 16'(doneCnt), 16'd1);

    // Start held high with new operands during RUN is ignored
    @(negedge clk);
    applyStimulus(8'd13, 8'd11, 1'b1);
    checkOutput("hold_start_product", product, 16'h008F);
    checkOutput("hold_start_done_count", 16'(doneCnt), 16'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold_start_no_requeue", {15'd0, busy}, 16'd0);

    // Reset during the fourth RUN cycle of 100 * 100
    @(negedge clk);
    a     = 8'd100;
    b     = 8'd100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre_abort_busy", {15'd0, busy}, 16'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {15'd0, busy}, 16'd0);
    checkOutput("abort_done", {15'd0, done}, 16'd0);
    checkOutput("abort_product", product, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_no_done", {15'd0, done}, 16'd0);

    // First edge after reset release accepts 7 * 9
    rst_n = 1'b1;
    applyStimulus(8'd7, 8'd9, 1'b0);
    checkOutput("7x9_product", product, 16'd63);
    checkOutput("7x9_done_edge", 16'(doneEdge), 16'd8);
    checkOutput("7x9_done_count", 16'(doneCnt), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-004 The block SHALL have port a, input, 8 bits: unsigned multiplicand, captured on accepted start.
REQ-005 The block SHALL have port b, input, 8 bits: unsigned multiplier, captured on accepted start.
REQ-006 The block SHALL have port oe, input, 1 bit: output enable for the product bus.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: high for exactly one cycle while in DONE.
REQ-009 The block SHALL have port product, output (tri-state), 16 bits: result register, driven when oe=1, else high-Z on all bits.

Function
REQ-010 The block SHALL implement the states IDLE, RUN and DONE, encoded in a 2-bit state register.
REQ-011 In IDLE with start=1 at edge N, the block SHALL capture a into mcand and b into mplier, clear acc_hi (8 bits), set count=0, and enter RUN.
REQ-012 Each RUN cycle SHALL use a single shared 8-bit ripple adder with 9-bit sum = acc_hi + (mplier[0] ? mcand : 0).
REQ-013 Each RUN cycle SHALL shift {sum[8:0], acc_lo} right by one into {acc_hi, acc_lo}, shift mplier right by one, and increment count.
REQ-014 The block SHALL leave RUN for DONE on the edge where count reaches 7 (the 8th iteration), which is edge N+8.
REQ-015 On entering DONE, product SHALL load {acc_hi, acc_lo}, giving done=1 in the cycle after edge N+8, and the next edge SHALL return the block to IDLE.
REQ-016 product SHALL hold its value until the next completed operation, and SHALL be unaffected by oe toggling.
REQ-017 The result SHALL equal a*b exactly for all 0..255 operands; no overflow is possible within 16 bits.
REQ-018 start SHALL be ignored in RUN and in DONE, with no re-capture and no queuing.
REQ-019 a and b SHALL be don't-care after the capture edge.
REQ-020 oe SHALL act combinationally on the product bus, with no cycle latency.

Reset
REQ-021 On rst_n=0, the block SHALL immediately (asynchronously) force state=IDLE, busy=0, done=0, product register=16'h0000, and mcand, mplier, acc, count = 0.
REQ-022 An assertion of rst_n mid-RUN SHALL abort the operation with no done pulse, and the product register SHALL read 0.
REQ-023 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Configuration
REQ-024 The macro MUL_SEQ_ZERO_SKIP_EN SHALL select the zero-skip behaviour.
REQ-025 With MUL_SEQ_ZERO_SKIP_EN defined, an accepted start with a==0 or b==0 SHALL go IDLE->DONE directly at edge N, load product=0, assert done in the cycle after edge N, and never assert busy.
REQ-026 Without MUL_SEQ_ZERO_SKIP_EN, zero operands SHALL take the full 8 RUN cycles like any other operands.

Verification
REQ-027 The bench SHALL check a=13, b=11, start pulse at edge N -> busy high for 8 cycles, done pulses once after edge N+8, product=16'h008F (143).
REQ-028 The bench SHALL check a=255, b=255 -> product=16'hFE01 (65025), exercising the carry-out of every adder stage.
REQ-029 The bench SHALL check a=0, b=200 -> product=0; done after edge N+8 without the macro, and done after edge N with the macro and busy never high.
REQ-030 The bench SHALL check that a second start, with new a=2, b=3, held high during RUN of 13*11 -> result 143, with exactly one done pulse.
REQ-031 The bench SHALL check rst_n low at RUN cycle 4 of 100*100 -> busy=0, done=0, product=0 immediately, and that a following 7*9 completes to 63.
REQ-032 The bench SHALL check oe=0 after 13*11 -> product=16'hZZZZ, and oe=1 -> product=143 with no intervening edge.
